mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_if.sv | 33 +++
 rtl/mc_control_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit_if.sv
// Control-unit handshake/bus bundle: instruction/status inputs from the datapath
// and the decoded control strobes back to it.
interface mc_control_unit_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic [2:0]  state;
    logic        ir_load;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        imm_load;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [31:0] retired;

    // Datapath / environment side: drives instruction and status, observes strobes.
    modport master (
        output opcode, mem_ready, branch_taken,
        input  state, ir_load, pc_write, pc_src, imm_load, alu_src_imm,
               mem_read, mem_write, reg_write, wb_sel, illegal, retired
    );

    // Control unit side.
    modport slave (
        input  opcode, mem_ready, branch_taken,
        output state, ir_load, pc_write, pc_src, imm_load, alu_src_imm,
               mem_read, mem_write, reg_write, wb_sel, illegal, retired
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32-style control unit: FETCH/DECODE/EXEC/MEM/WB(/TRAP) FSM with
// combinationally decoded control strobes and a retired-instruction counter.
// Handshake: memory accesses in FETCH and MEM complete in the cycle mem_ready is
// high; while it is low the FSM holds its state and every output stays stable.
// Build option: define ILLEGAL_TRAP_EN to send unsupported opcodes to a sticky
// TRAP state (left only by rst); otherwise they retire as NOPs.
module mc_control_unit (
    input  logic              clk,
    input  logic              rst,
    mc_control_unit_if.slave  bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_ALUI   = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_ALU    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_retired;
    logic        w_supported;
    logic        w_retire;

    // Opcode legality check
    always_comb begin
        w_supported = 1'b0;
        case (bus.opcode)
            OP_LOAD, OP_ALUI, OP_AUIPC, OP_STORE, OP_ALU,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: w_supported = 1'b1;
            default:                            w_supported = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_supported) begin
                    w_next = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    OP_BRANCH:         w_next = S_FETCH;
                    default:           w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.mem_ready) w_next = (bus.opcode == OP_LOAD) ? S_WB : S_FETCH;
            end
            S_WB: w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: w_next = S_TRAP;
`else
            // Unreachable without the trap option; recover to FETCH.
            S_TRAP: w_next = S_FETCH;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // An instruction completes on any return to FETCH from a working state;
    // without the trap option an unsupported opcode also retires from DECODE.
    always_comb begin
        w_retire = 1'b0;
        if (w_next == S_FETCH) begin
            case (r_state)
                S_EXEC, S_MEM, S_WB: w_retire = 1'b1;
`ifndef ILLEGAL_TRAP_EN
                S_DECODE:            w_retire = 1'b1;
`endif
                default:             w_retire = 1'b0;
            endcase
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_retired <= 32'd0;
        else if (w_retire) r_retired <= r_retired + 32'd1;
    end

    // Control-strobe decode from state and opcode
    always_comb begin
        bus.ir_load     = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 2'd0;
        bus.imm_load    = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.wb_sel      = 2'd0;
        case (r_state)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_load  = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            S_DECODE: bus.imm_load = 1'b1;
            S_EXEC: begin
                case (bus.opcode)
                    OP_ALUI, OP_LOAD, OP_STORE: bus.alu_src_imm = 1'b1;
                    OP_BRANCH: begin
                        if (bus.branch_taken) begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = 2'd1;
                        end
                    end
                    OP_JAL: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'd1;
                    end
                    OP_JALR: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_read  = (bus.opcode == OP_LOAD);
                bus.mem_write = (bus.opcode == OP_STORE);
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                case (bus.opcode)
                    OP_LOAD:         bus.wb_sel = 2'd1;
                    OP_JAL, OP_JALR: bus.wb_sel = 2'd2;
                    OP_LUI:          bus.wb_sel = 2'd3;
                    default:         bus.wb_sel = 2'd0;
                endcase
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = (r_state == S_TRAP);
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.state   = r_state;
    assign bus.retired = r_retired;
endmodule
